timer_irq: RTL and testbench

Memory-mapped countdown timer that generates the hardware interrupt line fed into CP0's `HWInt` input (bit 0 by convention). It sits on the CPU's peripheral bridge with three word registers: `CTRL`, `PRESET` and `COUNT`. It runs a four-state FSM and raises `irq` when the count expires. The interrupt is either level-held (one-shot mode) or a single-cycle pulse with automatic reload (periodic mode).

---
 rtl/timer_pkg.sv | 38 +++
 rtl/timer_irq.sv | 119 +++++++++++
 tb/tb_timer_irq.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// timer_pkg -- shared definitions for the timer_irq peripheral.
//   timer_state_t : countdown FSM states
//   ADDR_*        : word addresses of the bridge-visible registers
//   MODE_*        : CTRL.MODE encodings (2 and 3 behave as one-shot)
//   CTRL_*        : CTRL bit positions
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } timer_state_t;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam logic [1:0] MODE_ONESHOT  = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_MODE_LO = 1;
  localparam int unsigned CTRL_IM      = 3;

  // Implemented CTRL bits; everything above reads as zero.
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Only MODE_PERIODIC reloads; every other encoding is one-shot.
  function automatic logic is_periodic(input logic [1:0] mode);
    return (mode == MODE_PERIODIC);
  endfunction

endpackage

// File: rtl/timer_irq.sv
// timer_irq -- memory-mapped countdown timer driving CP0 HWInt.
// Registers (word address): 0 CTRL {IM, MODE[1:0], EN}, 1 PRESET (r/w),
// 2 COUNT (read-only), 3 unused (reads 0).
// Ports:
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-high clear of all state
//   we     : write strobe, sampled on the rising edge
//   addr   : word address (byte address bits [3:2])
//   din    : write data
//   dout   : combinational read data selected by addr
//   irq    : interrupt request = irq_flag & CTRL.IM
module timer_irq
  import timer_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          we,
  input  logic [1:0]    addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic          irq
);

  timer_state_t  state_q, state_d;
  ctrl_t         ctrl_q, ctrl_d;
  logic [DW-1:0] preset_q, preset_d;
  logic [DW-1:0] count_q, count_d;
  logic          flag_q, flag_d;

  logic wr_ctrl;
  logic wr_preset;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;

    unique case (state_q)
      IDLE: begin
        if (ctrl_q.en) state_d = LOAD;
      end
      // LOAD always completes, even if EN was just cleared; CNT then exits.
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q.en) begin
          state_d = IDLE;
        end else if (count_q == '0) begin
          state_d = INT;
          flag_d  = 1'b1;
        end else begin
          count_d = count_q - DW'(1);
        end
      end
      INT: begin
        state_d = IDLE;
        if (is_periodic(ctrl_q.mode)) flag_d = 1'b0;
        else                          ctrl_d.en = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    // Bus writes are applied last so a CPU CTRL write overrides the hardware
    // EN clear in INT, and any CTRL/PRESET write acknowledges the interrupt
    // even on the edge that would otherwise raise it.
    if (wr_ctrl) begin
      ctrl_d.en   = din[CTRL_EN];
      ctrl_d.mode = din[CTRL_MODE_LO +: 2];
      ctrl_d.im   = din[CTRL_IM];
      flag_d      = 1'b0;
    end
    if (wr_preset) begin
      preset_d = din;
      flag_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end

  always_comb begin
    dout = '0;
    unique case (addr)
      ADDR_CTRL: begin
        dout[CTRL_EN]            = ctrl_q.en;
        dout[CTRL_MODE_LO +: 2]  = ctrl_q.mode;
        dout[CTRL_IM]            = ctrl_q.im;
      end
      ADDR_PRESET: dout = preset_q;
      ADDR_COUNT:  dout = count_q;
      default:     dout = '0;
    endcase
  end

  assign irq = flag_q & ctrl_q.im;

endmodule

// File: tb/tb_timer_irq.sv
// Bench for timer_irq: directed scenarios with literal expectations plus a
// randomized bus-write phase, all cross-checked each cycle against a
// behavioural model of the timer.
module tb_timer_irq;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          we = 1'b0;
  logic [1:0]    addr = 2'd0;
  logic [DW-1:0] din = '0;
  logic [DW-1:0] dout;
  logic          irq;

  timer_irq #(.DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .addr  (addr),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int PH_IDLE = 0, PH_LOAD = 1, PH_CNT = 2, PH_INT = 3;
  bit        m_en, m_im, m_flag;
  bit [1:0]  m_mode;
  bit [31:0] m_preset, m_count;
  int        m_phase;

  task automatic model_clear();
    m_en = 0; m_im = 0; m_flag = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_phase = PH_IDLE;
  endtask

  task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
    bit        en   = m_en;
    bit        flag = m_flag;
    bit [31:0] cnt  = m_count;
    int        ph   = m_phase;
    case (m_phase)
      PH_IDLE: if (m_en) ph = PH_LOAD;
      PH_LOAD: begin cnt = m_preset; ph = PH_CNT; end
      PH_CNT: begin
        if (!m_en) ph = PH_IDLE;
        else if (m_count == 0) begin ph = PH_INT; flag = 1; end
        else cnt = m_count - 1;
      end
      default: begin
        ph = PH_IDLE;
        if (m_mode == 2'd1) flag = 0;
        else en = 0;
      end
    endcase
    m_count = cnt; m_phase = ph; m_en = en; m_flag = flag;
    if (w && a == 2'd0) begin
      m_en = d[0]; m_mode = d[2:1]; m_im = d[3]; m_flag = 0;
    end
    if (w && a == 2'd1) begin
      m_preset = d; m_flag = 0;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return {28'd0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'd0;
    endcase
  endfunction

  initial model_clear();
  always @(posedge reset) model_clear();
  always @(posedge clk) if (!reset) model_edge(we, addr, din);

  always @(negedge clk) begin
    check("model_irq", {31'd0, irq}, {31'd0, m_flag & m_im});
    check("model_dout", dout, model_read(addr));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; din = d;
    tick();
    we = 1'b0; din = '0;
  endtask

  task automatic chk_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(name, dout, exp);
  endtask

  task automatic chk_irq(input string name, input logic exp);
    check(name, {31'd0, irq}, {31'd0, exp});
  endtask

  logic [31:0] ctrl_tab [0:9];
  logic [31:0] c1;

  initial begin
    ctrl_tab[0] = 32'h9; ctrl_tab[1] = 32'hB; ctrl_tab[2] = 32'h1; ctrl_tab[3] = 32'h8;
    ctrl_tab[4] = 32'h0; ctrl_tab[5] = 32'hD; ctrl_tab[6] = 32'hB; ctrl_tab[7] = 32'h9;
    ctrl_tab[8] = 32'h3; ctrl_tab[9] = 32'hF;

    // Reset, then idle with no writes.
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      chk_irq("idle_irq", 1'b0);
      chk_rd("idle_read", 2'(i % 4), 32'd0);
      tick();
    end

    // One-shot, PRESET = 5.
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    idle(2); chk_rd("os_count_e2", 2'd2, 32'd5);
    idle(5); chk_rd("os_count_e7", 2'd2, 32'd0); chk_irq("os_irq_e7", 1'b0);
    idle(1); chk_irq("os_irq_e8", 1'b1);
    idle(3); chk_irq("os_irq_held", 1'b1); chk_rd("os_ctrl_en_cleared", 2'd0, 32'h8);
    wr(2'd0, 32'h8); chk_irq("os_irq_ack", 1'b0);

    // Periodic, PRESET = 3: pulses at e6, e13, e20.
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    idle(6); chk_irq("per_irq_e6", 1'b1);
    idle(1); chk_irq("per_irq_e7", 1'b0); chk_rd("per_ctrl_en_kept", 2'd0, 32'hB);
    idle(5); chk_irq("per_irq_e12", 1'b0);
    idle(1); chk_irq("per_irq_e13", 1'b1);
    idle(7); chk_irq("per_irq_e20", 1'b1);
    idle(1); chk_irq("per_irq_e21", 1'b0);
    wr(2'd0, 32'h0);
    idle(4);

    // Masked interrupt.
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    idle(5); chk_irq("mask_irq_e5", 1'b0);
    idle(1); chk_rd("mask_ctrl_e6", 2'd0, 32'h0);
    wr(2'd0, 32'h8); chk_irq("mask_unmask_ack", 1'b0); chk_rd("mask_ctrl_im", 2'd0, 32'h8);

    // Pause and resume, PRESET = 10.
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    idle(6); chk_rd("pause_count_e6", 2'd2, 32'd6);
    wr(2'd0, 32'h8);
    addr = 2'd2; #1; c1 = dout;
    check("pause_freeze", c1, 32'd5);
    idle(5); chk_rd("pause_hold", 2'd2, c1);
    wr(2'd0, 32'h9);
    idle(2); chk_rd("pause_reload", 2'd2, 32'd10);
    wr(2'd0, 32'h8);
    idle(4);

    // PRESET = 0, ignored addresses, CTRL upper bits.
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    idle(2); chk_irq("p0_irq_e2", 1'b0);
    idle(1); chk_irq("p0_irq_e3", 1'b1);
    idle(1);
    wr(2'd2, 32'h1234);
    chk_rd("addr2_ignored", 2'd2, 32'd0); chk_irq("addr2_no_ack", 1'b1);
    wr(2'd3, 32'hFFFF_FFFF);
    chk_rd("addr3_reads0", 2'd3, 32'd0); chk_irq("addr3_no_ack", 1'b1);
    chk_rd("addr3_no_alias", 2'd1, 32'd0);
    wr(2'd0, 32'hFFFF_FFFF);
    chk_rd("ctrl_upper_zero", 2'd0, 32'hF); chk_irq("ctrl_write_ack", 1'b0);
    wr(2'd0, 32'h0);
    idle(4);

    // Asynchronous reset while irq is high.
    wr(2'd0, 32'h9);
    idle(3); chk_irq("rst_irq_before", 1'b1);
    addr = 2'd0;
    reset = 1'b1;
    #1 chk_irq("rst_irq_async", 1'b0); check("rst_ctrl_async", dout, 32'd0);
    #1 reset = 1'b0;
    tick();

    // Asynchronous reset mid-count.
    wr(2'd1, 32'd100);
    wr(2'd0, 32'h9);
    idle(10); chk_rd("rst_count_before", 2'd2, 32'd92);
    reset = 1'b1;
    #1 check("rst_count_async", dout, 32'd0); chk_irq("rst_irq_low", 1'b0);
    #1 reset = 1'b0;
    tick();

    // Randomized bus traffic; the model compare covers every cycle.
    for (int i = 0; i < 3000; i++) begin
      addr = 2'($urandom_range(0, 3));
      we   = ($urandom_range(0, 19) == 0);
      if (addr == 2'd0)
        din = ($urandom_range(0, 15) == 0) ? $urandom : ctrl_tab[$urandom_range(0, 9)];
      else if (addr == 2'd1)
        din = ($urandom_range(0, 31) == 0) ? $urandom : 32'($urandom_range(0, 6));
      else
        din = $urandom;
      tick();
    end
    we = 1'b0;
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
